uart_rx_byte_pusher: RTL

//  UART receiver. Sits directly upstream of the byte FIFO and is that FIFO's only writer.
//  - Oversamples the serial rxd line: 8N1 frames, optional even parity.
//  - Each good byte becomes one single-cycle FIFO write.
//  - Framing, overrun and parity faults are reported as sticky flags.

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_rx_sync.sv | 16 +
 rtl/uart_rx_byte_pusher.sv | 111 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the UART receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;
    localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for an asynchronous input, reset to RESET_VAL
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;
    always_ff @(posedge clk) begin
        if (!reset_n) ff_q <= {2{RESET_VAL}};
        else          ff_q <= {ff_q[0], d_i};
    end
    assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx_byte_pusher.sv
// uart_rx_byte_pusher: oversampling 8N1 UART receiver writing good bytes into a FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_byte_pusher
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rxd,
    input  logic                      fifo_write_ready,
    output logic                      fifo_write_enable,
    output logic [UART_DATA_BITS-1:0] fifo_write_data,
    input  logic                      error_clear,
    output logic                      frame_error,
    output logic                      overrun_error,
    output logic                      parity_error
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
`ifdef UART_RX_PARITY_EN
    localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
    localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                      par_bad_q, par_bad_d;
    logic                      we_q, we_d, fe_q, fe_d, oe_q, oe_d, pe_q, pe_d;
    logic                      rxd_s, tick, stop_hit, good;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rxd),
        .q_o     (rxd_s)
    );

    assign tick = cnt_q == '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            we_q      <= 1'b0;
            data_q    <= '0;
            fe_q      <= 1'b0;
            oe_q      <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            we_q      <= we_d;
            data_q    <= data_d;
            fe_q      <= fe_d;
            oe_q      <= oe_d;
            pe_q      <= pe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!rxd_s) state_d = START;
            START:   if (tick) state_d = rxd_s ? IDLE : DATA;
            DATA:    if (tick && idx_q == 3'(UART_DATA_BITS - 1)) state_d = AFTER_DATA;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = (state_q == IDLE) ? HALF : tick ? FULL : cnt_q - CW'(1);
        idx_d   = (state_q != DATA) ? '0 : idx_q + 3'(tick);
        shift_d = (state_q == DATA && tick) ? {rxd_s, shift_q[UART_DATA_BITS-1:1]} : shift_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d = (state_q == START) ? 1'b0 : (state_q == PARITY && tick) ? ^{shift_q, rxd_s} : par_bad_q;
`else
        par_bad_d = 1'b0;
`endif
        // Outcome is decided at the stop sample; a rejected parity drops the byte before overrun is considered.
        stop_hit = state_q == STOP && tick;
        good     = stop_hit && rxd_s && !par_bad_q;
        we_d     = good && fifo_write_ready;
        data_d   = we_d ? shift_q : data_q;
        fe_d     = (stop_hit && !rxd_s) || (fe_q && !error_clear);
        oe_d     = (good && !fifo_write_ready) || (oe_q && !error_clear);
        pe_d     = (stop_hit && par_bad_q) || (pe_q && !error_clear);
    end

    assign fifo_write_enable = we_q;
    assign fifo_write_data   = data_q;
    assign frame_error       = fe_q;
    assign overrun_error     = oe_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error      = pe_q;
`else
    assign parity_error      = 1'b0;
`endif
endmodule
